// File: rtl/pipe_pkg.sv
// Shared sizing helpers for the elastic pipeline: each slice holds a main and a skid entry.
package pipe_pkg;

    localparam int SLOTS_PER_SLICE = 2;

    function automatic int max_occupancy(input int depth);
        return SLOTS_PER_SLICE * depth;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(max_occupancy(depth) + 1);
    endfunction

endpackage

// File: rtl/module_pipe_slice.sv
// One elastic slice: main register plus skid register, ready driven only from the skid valid flop.
module module_pipe_slice #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    // Handshake: a beat moves on a posedge where valid and ready are both high;
    // valid never waits on ready, and ready here is purely registered.
    assign in_ready_o  = ~skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (!main_v_q || out_ready_i) begin
            // Main is empty or draining: a parked skid entry goes first to keep order.
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_valid_i;
                if (in_valid_i) begin
                    main_d = in_data_i;
                end
            end
        end else if (in_valid_i && !skid_v_q) begin
            skid_d   = in_data_i;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= RESET_VAL;
            skid_q   <= RESET_VAL;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/module_pipe_elastic.sv
// Elastic register chain of DEPTH main+skid slices with flush and a registered occupancy count.
module module_pipe_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          s_valid_i,
    input  logic [WIDTH-1:0]              s_data_i,
    output logic                          s_ready_o,
    output logic                          m_valid_o,
    output logic [WIDTH-1:0]              m_data_o,
    input  logic                          m_ready_i,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH:0]            vld;
    logic [DEPTH:0]            rdy;
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [CW-1:0]             count_q, count_d;
    logic                      in_fire, out_fire;

    assign vld[0]     = s_valid_i;
    assign dat[0]     = s_data_i;
    assign rdy[DEPTH] = m_ready_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        module_pipe_slice #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_slice (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .in_valid_i  (vld[k]),
            .in_data_i   (dat[k]),
            .in_ready_o  (rdy[k]),
            .out_valid_o (vld[k+1]),
            .out_data_o  (dat[k+1]),
            .out_ready_i (rdy[k+1])
        );
    end

    assign s_ready_o = rdy[0] & ~rst_i;
    assign m_valid_o = vld[DEPTH];
    assign m_data_o  = dat[DEPTH];
    assign count_o   = count_q;

    assign in_fire  = s_valid_i & s_ready_o;
    assign out_fire = m_valid_o & m_ready_i;

    always_comb begin
        count_d = count_q;
        if (in_fire && !out_fire) begin
            count_d = count_q + CW'(1);
        end else if (out_fire && !in_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_module_pipe_elastic.sv
// Bench for module_pipe_elastic (WIDTH=32, DEPTH=3): scenario tasks checked against a FIFO reference queue.
module tb_module_pipe_elastic;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 3;
    localparam int          CW     = 3;
    localparam logic [31:0] RST_V  = 32'hDEAD_BEEF;
    localparam int          CAP    = 2 * DEPTH;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             s_valid_i = 1'b0;
    logic [WIDTH-1:0] s_data_i = '0;
    logic             s_ready_o;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i = 1'b0;
    logic [CW-1:0]    count_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];

    logic             smp_ready, smp_mvalid;
    logic [WIDTH-1:0] smp_mdata;
    logic [CW-1:0]    smp_count;

    always #5 clk = ~clk;

    module_pipe_elastic #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RST_V)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .count_o   (count_o)
    );

    // Samples outputs mid-cycle, reports which handshakes complete at the next edge, then advances.
    task automatic cycle_step(output logic in_f, output logic out_f);
        @(negedge clk);
        smp_ready  = s_ready_o;
        smp_mvalid = m_valid_o;
        smp_mdata  = m_data_o;
        smp_count  = count_o;
        in_f  = s_valid_i && s_ready_o;
        out_f = m_valid_o && m_ready_i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic in_f, out_f;
        rst_i = 1'b1; flush_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h1234_5678; m_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle_step(in_f, out_f);
            n_checks++;
            if (smp_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready_low: got %0b want 0", smp_ready);
            end
        end
        rst_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        exp_q.delete();
        cycle_step(in_f, out_f);
        n_checks++;
        if (smp_mvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", smp_mvalid); end
        n_checks++;
        if (smp_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", smp_count); end
        n_checks++;
        if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %0b want 1", smp_ready); end
        n_checks++;
        if (smp_mdata !== RST_V) begin n_fail++; $display("FAIL reset_m_data: got %h want %h", smp_mdata, RST_V); end
    endtask

    task automatic test_stream();
        logic in_f, out_f;
        int   pushed = 0, popped = 0, t_in = -1, t_out = -1;
        m_ready_i = 1'b1;
        for (int k = 0; k < 60 && popped < 16; k++) begin
            s_valid_i = (pushed < 16);
            s_data_i  = 32'(pushed + 1);
            cycle_step(in_f, out_f);
            n_checks++;
            if (smp_count !== CW'(exp_q.size())) begin
                n_fail++; $display("FAIL stream_count: got %0d want %0d", smp_count, exp_q.size());
            end
            if (pushed < 16) begin
                n_checks++;
                if (in_f !== 1'b1) begin n_fail++; $display("FAIL stream_throughput: got accept %0b want 1", in_f); end
            end
            if (in_f) begin
                if (t_in < 0) t_in = k;
                exp_q.push_back(s_data_i);
                pushed++;
            end
            if (out_f) begin
                if (t_out < 0) begin
                    t_out = k;
                    n_checks++;
                    if (smp_count !== 3'd3) begin n_fail++; $display("FAIL stream_steady_count: got %0d want 3", smp_count); end
                end
                n_checks++;
                if (exp_q.size() == 0 || smp_mdata !== exp_q[0]) begin
                    n_fail++; $display("FAIL stream_data: got %h want %h", smp_mdata, (exp_q.size() != 0) ? exp_q[0] : 32'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                popped++;
            end
        end
        s_valid_i = 1'b0;
        n_checks++;
        if (popped != 16) begin n_fail++; $display("FAIL stream_timeout: got %0d outputs want 16", popped); end
        n_checks++;
        if (t_out - t_in != DEPTH) begin n_fail++; $display("FAIL stream_latency: got %0d want %0d", t_out - t_in, DEPTH); end
    endtask

    task automatic test_backpressure();
        logic in_f, out_f;
        int   acc = 0;
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            s_data_i = $urandom;
            cycle_step(in_f, out_f);
            if (in_f) begin exp_q.push_back(s_data_i); acc++; end
        end
        cycle_step(in_f, out_f);
        n_checks++;
        if (acc != CAP) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", acc, CAP); end
        n_checks++;
        if (smp_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b want 0", smp_ready); end
        n_checks++;
        if (smp_count !== CW'(CAP)) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", smp_count, CAP); end
    endtask

    task automatic test_full_release();
        logic in_f, out_f;
        logic [WIDTH-1:0] blocked;
        int   guard = 0;
        blocked   = 32'hC0FF_EE00;
        s_valid_i = 1'b1;
        s_data_i  = blocked;
        m_ready_i = 1'b1;
        cycle_step(in_f, out_f);
        n_checks++;
        if (in_f !== 1'b0) begin n_fail++; $display("FAIL full_in_blocked: got %0b want 0", in_f); end
        n_checks++;
        if (out_f !== 1'b1 || smp_mdata !== exp_q[0]) begin
            n_fail++; $display("FAIL full_out: got fire %0b data %h want fire 1 data %h", out_f, smp_mdata, exp_q[0]);
        end
        if (in_f) exp_q.push_back(s_data_i);
        if (out_f) void'(exp_q.pop_front());
        s_valid_i = 1'b0;
        m_ready_i = 1'($urandom_range(0, 1));
        cycle_step(in_f, out_f);
        n_checks++;
        if (smp_count !== CW'(CAP - 1)) begin n_fail++; $display("FAIL full_count_after: got %0d want %0d", smp_count, CAP - 1); end
        if (out_f) void'(exp_q.pop_front());
        // Drain under random back-pressure and confirm order.
        while (exp_q.size() != 0 && guard < 200) begin
            m_ready_i = 1'($urandom_range(0, 1));
            cycle_step(in_f, out_f);
            guard++;
            if (out_f) begin
                n_checks++;
                if (smp_mdata !== exp_q[0]) begin n_fail++; $display("FAIL drain_data: got %h want %h", smp_mdata, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        m_ready_i = 1'b0;
        cycle_step(in_f, out_f);
        n_checks++;
        if (smp_count !== 3'd0 || smp_mvalid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got count %0d valid %0b want 0 0", smp_count, smp_mvalid);
        end
    endtask

    task automatic test_flush();
        logic in_f, out_f;
        logic [WIDTH-1:0] killed;
        int   acc = 0, popped = 0;
        killed    = 32'h0BAD_F00D;
        m_ready_i = 1'b0;
        for (int k = 0; k < 20 && acc < 4; k++) begin
            s_valid_i = 1'b1;
            s_data_i  = $urandom;
            cycle_step(in_f, out_f);
            if (in_f) begin exp_q.push_back(s_data_i); acc++; end
        end
        s_valid_i = 1'b1; s_data_i = killed; flush_i = 1'b1;
        m_ready_i = 1'($urandom_range(0, 1));
        cycle_step(in_f, out_f);
        flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b1;
        exp_q.delete();
        cycle_step(in_f, out_f);
        n_checks++;
        if (smp_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", smp_count); end
        n_checks++;
        if (smp_mvalid !== 1'b0) begin n_fail++; $display("FAIL flush_m_valid: got %0b want 0", smp_mvalid); end
        n_checks++;
        if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", smp_ready); end
        for (int k = 0; k < 30 && popped < 5; k++) begin
            s_valid_i = (k < 5);
            s_data_i  = 32'hA000_0000 + 32'(k);
            cycle_step(in_f, out_f);
            if (in_f) exp_q.push_back(s_data_i);
            if (out_f) begin
                n_checks++;
                if (smp_mdata === killed || exp_q.size() == 0 || smp_mdata !== exp_q[0]) begin
                    n_fail++; $display("FAIL flush_after_data: got %h", smp_mdata);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                popped++;
            end
        end
        s_valid_i = 1'b0;
        n_checks++;
        if (popped != 5) begin n_fail++; $display("FAIL flush_restart: got %0d outputs want 5", popped); end
    endtask

    task automatic test_reset_midstream();
        logic in_f, out_f;
        int   acc = 0, popped = 0;
        m_ready_i = 1'b0;
        for (int k = 0; k < 20 && acc < 5; k++) begin
            s_valid_i = 1'b1;
            s_data_i  = $urandom;
            cycle_step(in_f, out_f);
            if (in_f) begin exp_q.push_back(s_data_i); acc++; end
        end
        n_checks++;
        if (acc != 5) begin n_fail++; $display("FAIL midrst_load: got %0d want 5", acc); end
        rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'h5555_AAAA; m_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle_step(in_f, out_f);
            n_checks++;
            if (smp_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %0b want 0", smp_ready); end
        end
        rst_i = 1'b0; s_valid_i = 1'b0;
        exp_q.delete();
        cycle_step(in_f, out_f);
        n_checks++;
        if (smp_count !== 3'd0 || smp_mvalid !== 1'b0 || smp_ready !== 1'b1 || smp_mdata !== RST_V) begin
            n_fail++; $display("FAIL midrst_state: got count %0d valid %0b ready %0b data %h", smp_count, smp_mvalid, smp_ready, smp_mdata);
        end
        for (int k = 0; k < 40 && popped < 8; k++) begin
            s_valid_i = (k < 8);
            s_data_i  = $urandom;
            cycle_step(in_f, out_f);
            if (in_f) exp_q.push_back(s_data_i);
            if (out_f) begin
                n_checks++;
                if (exp_q.size() == 0 || smp_mdata !== exp_q[0]) begin
                    n_fail++; $display("FAIL midrst_restart_data: got %h", smp_mdata);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                popped++;
            end
        end
        s_valid_i = 1'b0;
        n_checks++;
        if (popped != 8) begin n_fail++; $display("FAIL midrst_restart: got %0d outputs want 8", popped); end
    endtask

    task automatic test_random();
        logic in_f, out_f;
        int   guard = 0;
        for (int k = 0; k < 400; k++) begin
            s_valid_i = ($urandom_range(0, 9) < 7);
            s_data_i  = $urandom;
            m_ready_i = ($urandom_range(0, 9) < 5);
            cycle_step(in_f, out_f);
            n_checks++;
            if (smp_count !== CW'(exp_q.size())) begin
                n_fail++; $display("FAIL rand_count: got %0d want %0d", smp_count, exp_q.size());
            end
            if (exp_q.size() == CAP) begin
                n_checks++;
                if (smp_ready !== 1'b0) begin n_fail++; $display("FAIL rand_full_ready: got %0b want 0", smp_ready); end
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                if (smp_mvalid !== 1'b0) begin n_fail++; $display("FAIL rand_empty_valid: got %0b want 0", smp_mvalid); end
            end
            if (smp_mvalid && exp_q.size() != 0) begin
                n_checks++;
                if (smp_mdata !== exp_q[0]) begin n_fail++; $display("FAIL rand_data: got %h want %h", smp_mdata, exp_q[0]); end
            end
            if (in_f) exp_q.push_back(s_data_i);
            if (out_f && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        while (exp_q.size() != 0 && guard < 50) begin
            cycle_step(in_f, out_f);
            guard++;
            if (out_f) begin
                n_checks++;
                if (smp_mdata !== exp_q[0]) begin n_fail++; $display("FAIL rand_drain: got %h want %h", smp_mdata, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain_timeout: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_release();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
